// File: rtl/interleaver_pkg.sv
// Shared constants and index math for the WiMAX bit interleaver.
// Optional build macro: INTERLEAVER_REG_OUT_EN (registered outputs).
package interleaver_pkg;

    // QPSK default configuration
    localparam int NCBPS_QPSK = 192;
    localparam int NCPC_QPSK  = 2;
    localparam int D_QPSK     = 16;

    // second-permutation group size, never below 1
    function automatic int calc_s(input int ncpc);
        int s_raw;
        s_raw = ncpc / 2;
        return (s_raw < 1) ? 1 : s_raw;
    endfunction

    // destination position j of input bit k inside an ncbps-bit block
    function automatic int calc_index(
        input int k,
        input int ncbps,
        input int d,
        input int s
    );
        int m;
        int j;
        m = (ncbps / d) * (k % d) + (k / d);
        j = s * (m / s) + ((m + ncbps - ((d * m) / ncbps)) % s);
        return j;
    endfunction

endpackage

// File: rtl/interleaver_index_gen.sv
// Constant lookup of the interleaved position for input counter k.
// Table contents are fixed at elaboration, no runtime division.
module interleaver_index_gen
    import interleaver_pkg::*;
#(
    parameter int Ncbps = NCBPS_QPSK,
    parameter int d     = D_QPSK,
    parameter int s     = 1,
    parameter int W     = $clog2(Ncbps)
) (
    input  logic [W-1:0] k,
    output logic [W-1:0] j
);

    logic [W-1:0] rom [Ncbps];

    for (genvar i = 0; i < Ncbps; i++) begin : g_rom
        assign rom[i] = W'(calc_index(i, Ncbps, d, s));
    end

    // k never leaves 0..Ncbps-1, so the table covers every reachable value
    assign j = rom[k];

endmodule

// File: rtl/interleaver.sv
// Bit-serial WiMAX block interleaver: passes each bit through tagged
// with its interleaved index. Optional macro INTERLEAVER_REG_OUT_EN.
module interleaver
    import interleaver_pkg::*;
#(
    parameter int Ncbps = NCBPS_QPSK,
    parameter int Ncpc  = NCPC_QPSK,
    parameter int d     = D_QPSK,
    localparam int s    = calc_s(Ncpc),
    localparam int W    = $clog2(Ncbps)
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         ready_buffer,
    input  logic         valid_fec,
    input  logic         data_in,
    output logic         data_out,
    output logic [W-1:0] data_out_index,
    output logic         ready_interleaver,
    output logic         valid_interleaver
);

    if ((Ncbps % d) != 0 || s < 1 || Ncpc < 1) begin : g_param_err
        $error("interleaver: Ncbps must be a multiple of d and s >= 1");
    end

    logic [W-1:0] k;
    logic [W-1:0] j;
    logic         xfer;

    assign xfer = valid_fec && ready_buffer && !resetN;

    // input bit counter, wraps at the block boundary without a bubble
    always_ff @(posedge clk) begin
        if (resetN) begin
            k <= '0;
        end else if (xfer) begin
            if (k == W'(Ncbps - 1)) begin
                k <= '0;
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    interleaver_index_gen #(
        .Ncbps (Ncbps),
        .d     (d),
        .s     (s),
        .W     (W)
    ) u_index_gen (
        .k (k),
        .j (j)
    );

    assign ready_interleaver = ready_buffer && !resetN;

`ifdef INTERLEAVER_REG_OUT_EN
    // output stage loads on each transfer, valid drops on any idle cycle
    always_ff @(posedge clk) begin
        if (resetN) begin
            data_out          <= 1'b0;
            data_out_index    <= '0;
            valid_interleaver <= 1'b0;
        end else if (xfer) begin
            data_out          <= data_in;
            data_out_index    <= j;
            valid_interleaver <= 1'b1;
        end else begin
            valid_interleaver <= 1'b0;
        end
    end
`else
    // zero-latency outputs, forced quiet while reset is held
    always_comb begin
        data_out          = data_in && !resetN;
        data_out_index    = resetN ? '0 : j;
        valid_interleaver = valid_fec && !resetN;
    end
`endif

endmodule

// File: tb/tb_interleaver.sv
// Directed bench for the interleaver: golden block, streaming,
// stalls and mid-block reset.
module tb_interleaver;

    localparam int N = 192;
    localparam logic [N-1:0] GIN  =
        192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
    localparam logic [N-1:0] GOUT =
        192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       ready_buffer = 1'b0;
    logic       valid_fec = 1'b0;
    logic       data_in = 1'b0;
    logic       data_out;
    logic [7:0] data_out_index;
    logic       ready_interleaver;
    logic       valid_interleaver;

    int checks = 0;
    int failures = 0;

    logic [N-1:0] gin;
    logic [N-1:0] scat;
    logic [N-1:0] blk_q[$];
    int           cnt = 0;

    int spot_k[6] = '{0, 1, 15, 16, 17, 191};
    int spot_j[6] = '{0, 12, 180, 1, 13, 191};

    interleaver dut (
        .clk               (clk),
        .resetN            (resetN),
        .ready_buffer      (ready_buffer),
        .valid_fec         (valid_fec),
        .data_in           (data_in),
        .data_out          (data_out),
        .data_out_index    (data_out_index),
        .ready_interleaver (ready_interleaver),
        .valid_interleaver (valid_interleaver)
    );

    always #5 clk = ~clk;

    // scatter accepted bits by their index, one queue entry per block
    always @(negedge clk) begin
        logic take;
`ifdef INTERLEAVER_REG_OUT_EN
        take = valid_interleaver;
`else
        take = valid_interleaver && ready_interleaver;
`endif
        if (resetN) begin
            cnt = 0;
        end else if (take) begin
            scat[N - 1 - int'(data_out_index)] = data_out;
            cnt++;
            if (cnt == N) begin
                blk_q.push_back(scat);
                cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [N-1:0] got,
                       input logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic v, input logic r, input logic rs,
                       input logic b);
        @(posedge clk);
        #1;
        valid_fec    = v;
        ready_buffer = r;
        resetN       = rs;
        data_in      = b;
        @(negedge clk);
    endtask

    task automatic chk_blocks(input string tag, input int n);
        put(1'b0, 1'b1, 1'b0, 1'b0);
        put(1'b0, 1'b1, 1'b0, 1'b0);
        chk($sformatf("%s_count", tag), N'(blk_q.size()), N'(n));
        for (int i = 0; i < n; i++) begin
            if (blk_q.size() > 0) begin
                chk($sformatf("%s_blk%0d", tag, i), blk_q.pop_front(), GOUT);
            end
        end
        blk_q.delete();
    endtask

    initial begin
        gin = GIN;

        // reset: outputs quiet even with valid/ready/data high
        put(1'b1, 1'b1, 1'b1, 1'b1);
        put(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_data", N'(data_out), N'(0));
        chk("rst_index", N'(data_out_index), N'(0));
        chk("rst_valid", N'(valid_interleaver), N'(0));
        chk("rst_ready", N'(ready_interleaver), N'(0));

        // golden block with index spot checks
        for (int k = 0; k < N; k++) begin
            put(1'b1, 1'b1, 1'b0, gin[N-1-k]);
`ifndef INTERLEAVER_REG_OUT_EN
            for (int i = 0; i < 6; i++) begin
                if (spot_k[i] == k) begin
                    chk($sformatf("spot_k%0d", k), N'(data_out_index),
                        N'(spot_j[i]));
                end
            end
            if (k == 5) chk("pass_data", N'(data_out), N'(gin[N-1-k]));
`endif
        end
        chk_blocks("golden", 1);

        // ten back-to-back blocks, no gaps
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < N; k++) begin
                put(1'b1, 1'b1, 1'b0, gin[N-1-k]);
`ifndef INTERLEAVER_REG_OUT_EN
                if (k == 0) begin
                    chk($sformatf("wrap_first_b%0d", b),
                        N'(data_out_index), N'(0));
                end
                if (k == N - 1) begin
                    chk($sformatf("wrap_last_b%0d", b),
                        N'(data_out_index), N'(191));
                end
`endif
            end
        end
        chk_blocks("stream", 10);

        // stalls at k=50 on each side
        for (int k = 0; k < N; k++) begin
            if (k == 50) begin
                for (int c = 0; c < 3; c++) begin
                    put(1'b0, 1'b1, 1'b0, gin[N-1-k]);
`ifndef INTERLEAVER_REG_OUT_EN
                    chk($sformatf("vstall_idx%0d", c),
                        N'(data_out_index), N'(27));
                    chk($sformatf("vstall_valid%0d", c),
                        N'(valid_interleaver), N'(0));
`endif
                end
                for (int c = 0; c < 3; c++) begin
                    put(1'b1, 1'b0, 1'b0, gin[N-1-k]);
`ifndef INTERLEAVER_REG_OUT_EN
                    chk($sformatf("rstall_idx%0d", c),
                        N'(data_out_index), N'(27));
                    chk($sformatf("rstall_ready%0d", c),
                        N'(ready_interleaver), N'(0));
                    chk($sformatf("rstall_valid%0d", c),
                        N'(valid_interleaver), N'(1));
`endif
                end
            end
            put(1'b1, 1'b1, 1'b0, gin[N-1-k]);
        end
        chk_blocks("stall", 1);

        // reset at k=100 discards the partial block
        for (int k = 0; k < 100; k++) begin
            put(1'b1, 1'b1, 1'b0, gin[N-1-k]);
        end
        for (int c = 0; c < 2; c++) begin
            put(1'b1, 1'b1, 1'b1, 1'b1);
`ifndef INTERLEAVER_REG_OUT_EN
            chk($sformatf("mrst_data%0d", c), N'(data_out), N'(0));
            chk($sformatf("mrst_index%0d", c), N'(data_out_index), N'(0));
`endif
            chk($sformatf("mrst_valid%0d", c), N'(valid_interleaver),
                N'(c == 0 ? valid_interleaver : 1'b0));
            chk($sformatf("mrst_ready%0d", c), N'(ready_interleaver), N'(0));
        end
        for (int k = 0; k < N; k++) begin
            put(1'b1, 1'b1, 1'b0, gin[N-1-k]);
`ifndef INTERLEAVER_REG_OUT_EN
            if (k == 0) chk("mrst_first_idx", N'(data_out_index), N'(0));
`endif
        end
        chk_blocks("after_rst", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interleaver.md
Name: interleaver

Overview:
- Bit-serial WiMAX (802.16 OFDM) block interleaver, placed between the FEC encoder and the downstream symbol/mapper buffer.
- Accepts one coded bit per cycle and emits it immediately, tagged with its interleaved position inside an Ncbps-bit block.
- The downstream buffer writes each bit at that position.
- No block storage is held inside this module; the permutation is carried entirely by the emitted index.

Parameters:
- Ncbps, 192, coded bits per interleaver block (multiple of d).
- Ncpc, 2, coded bits per subcarrier (1 BPSK, 2 QPSK, 4 16QAM, 6 64QAM).
- s, Ncpc/2 (min 1), second-permutation group size.
- d, 16, first-permutation column count.

Ports:
- clk  in  1  rising-edge clock.
- resetN  in  1  synchronous active-high reset. The name is kept per codebase convention; the polarity is high.
- ready_buffer  in  1  downstream buffer can accept a bit.
- valid_fec  in  1  data_in holds a valid coded bit.
- data_in  in  1  serial coded bit from FEC.
- data_out  out  1  interleaved bit (same bit as data_in).
- data_out_index  out  $clog2(Ncbps)  destination position j(k) of the current bit.
- ready_interleaver  out  1  interleaver can accept a bit (to FEC).
- valid_interleaver  out  1  data_out/data_out_index valid.

Behaviour:
- Input counter k:
  - Width $clog2(Ncbps); reset value 0.
  - Increments on a rising clk when the transfer condition (valid_fec && ready_buffer && !resetN) holds.
  - Wraps from Ncbps-1 to 0. No gap between blocks; back-to-back blocks stream continuously.
- Index function, combinational from k:
  - m = (Ncbps/d)*(k mod d) + floor(k/d)
  - j = s*floor(m/s) + (m + Ncbps - floor(d*m/Ncbps)) mod s
  - data_out_index = j. For s=1, j = m = 12*(k mod 16) + k/16 at Ncbps=192.
- Implementation of the index function:
  - Compute all integer divides at elaboration, as a constant table or a constant-divisor form.
  - No runtime dividers.
- Datapath latency is zero in the default build:
  - data_out = data_in.
  - data_out_index reflects the current k, i.e. the index of the bit presented this cycle.
- Handshake:
  - ready_interleaver = ready_buffer && !resetN.
  - valid_interleaver = valid_fec && !resetN.
  - A stall on either side (valid_fec=0 or ready_buffer=0) freezes k; the outputs keep tracking the inputs.
- Reset (resetN=1):
  - k←0 at the next edge.
  - While reset is asserted: data_out=0, data_out_index=0, valid_interleaver=0, ready_interleaver=0.
  - A reset mid-block discards the partial block; the first bit after reset gets index j(0)=0.
- Simultaneous reset and transfer: reset wins; k=0.
- Parameter check: elaboration error if Ncbps mod d ≠ 0 or s<1.

Optional Feature:
- Macro INTERLEAVER_REG_OUT_EN.
- When defined:
  - data_out, data_out_index and valid_interleaver are registered, giving 1-cycle latency.
  - The registers load on transfer. valid_interleaver is cleared the cycle after a non-transfer and on reset.
  - ready_interleaver is unchanged.
- When undefined: the zero-latency combinational outputs described above.

Decomposition:
- Package interleaver_pkg holds:
  - function calc_index(k, Ncbps, d, s) returning j.
  - Localparam constants for the QPSK default (Ncbps=192, d=16).
- Sub-module interleaver_index_gen is natural:
  - Input k; output j.
  - Constant ROM filled via calc_index at elaboration.

Test Plan:
- Golden block:
  - Stimulus: stream data_in = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA, MSB first, valid_fec=1, ready_buffer=1.
  - Response: a scatter of data_out into data_out_index gives 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E.
- Index spot checks: k=0→0, 1→12, 15→180, 16→1, 17→13, 191→191.
- Streaming: 10 consecutive golden blocks with no gaps → every block matches; k wraps 191→0 without bubble.
- Stall:
  - Stimulus: drop valid_fec, then separately ready_buffer, for 3 cycles at k=50.
  - Response: data_out_index holds 12*2+3=27; the block still matches golden.
- Reset mid-block:
  - Stimulus: assert resetN at k=100 for 2 cycles.
  - Response: outputs 0, valid/ready 0; after release the first bit has index 0.
- With INTERLEAVER_REG_OUT_EN: golden block still matches, with each output delayed exactly 1 cycle.
